// File: rtl/ringbuf_tx_arbiter_pkg.sv
// ringbuf_tx_arbiter_pkg
// Shared definitions for the ring-buffer transmit arbiter: the arbiter state
// encoding and the counter-width helpers derived from the frame length.
// No ports.

package ringbuf_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StSend = 2'd2,
        StGap  = 2'd3
    } arb_state_e;

    // Gap counter width; covers GAP_BITS up to 15.
    localparam int unsigned GapCntW = 4;

    // Bit counter must hold the terminal value FRAME_BITS itself.
    function automatic int unsigned bit_cnt_width(input int unsigned frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

endpackage

// File: rtl/ringbuf_rr_pick.sv
// ringbuf_rr_pick
// Combinational masked round-robin picker: grants the lowest-indexed request
// at or above the pointer, wrapping to the lowest-indexed request overall.
// Ports:
//   req_i  - request vector
//   ptr_i  - round-robin start index
//   gnt_o  - one-hot grant (all zero when req_i is zero)

module ringbuf_rr_pick #(
    parameter int unsigned NReq = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [NReq-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NReq-1:0] gnt_o
);

    logic [NReq-1:0] masked;
    logic [NReq-1:0] src;
    logic            found;

    always_comb begin
        masked = '0;
        for (int i = 0; i < NReq; i++) begin
            masked[i] = req_i[i] && (PtrW'(i) >= ptr_i);
        end
        // Nothing at or above the pointer: wrap around to the full vector.
        src   = (|masked) ? masked : req_i;
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NReq; i++) begin
            if (src[i] && !found) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ringbuf_tx_arbiter.sv
// ringbuf_tx_arbiter
// Shares the ring buffer's serial transmit input among N_REQ requesters. One
// whole frame of FRAME_BITS bits is granted at a time, round-robin, paced by
// rising edges of txc, followed by GAP_BITS idle txc periods.
// Optional: define RINGBUF_TX_ARB_PRIORITY_EN to give requester 0 absolute
// priority at arbitration; the others stay round-robin among themselves.
// Ports:
//   clock      - system clock (same as ringbuf)
//   reset      - asynchronous active-low reset
//   req        - per-requester frame request, sampled only in arbitration
//   txd_in     - per-requester current serial bit
//   txc        - transmit bit strobe from ringbuf
//   gnt        - one-hot grant, held for the whole frame
//   bit_ack    - one-clock pulse: bit consumed, present the next one
//   txda       - serial data to ringbuf
//   busy       - frame or gap in progress
//   frame_done - one-clock pulse after the last bit of a frame

module ringbuf_tx_arbiter
    import ringbuf_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned GAP_BITS   = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] txd_in,
    input  logic             txc,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] bit_ack,
    output logic             txda,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BitCntW = bit_cnt_width(FRAME_BITS);
    localparam int unsigned PtrW    = $clog2(N_REQ);

    arb_state_e           state_q, state_d;
    logic                 txc_q;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [N_REQ-1:0]     bit_ack_q, bit_ack_d;
    logic                 txda_q, txda_d;
    logic                 frame_done_q, frame_done_d;
    logic [PtrW-1:0]      rr_q, rr_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GapCntW-1:0]   gap_cnt_q, gap_cnt_d;

    logic                 txc_rise;
    logic [N_REQ-1:0]     pick_req;
    logic [N_REQ-1:0]     pick_gnt;
    logic [N_REQ-1:0]     arb_gnt;
    logic [PtrW-1:0]      gnt_idx;
    logic [PtrW-1:0]      rr_next;

    assign txc_rise = txc & ~txc_q;

`ifdef RINGBUF_TX_ARB_PRIORITY_EN
    // Requester 0 is served outside the rotation, so hide it from the picker.
    assign pick_req = {req[N_REQ-1:1], 1'b0};
`else
    assign pick_req = req;
`endif

    ringbuf_rr_pick #(
        .NReq (N_REQ),
        .PtrW (PtrW)
    ) u_rr_pick (
        .req_i (pick_req),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt)
    );

    always_comb begin
        arb_gnt = pick_gnt;
`ifdef RINGBUF_TX_ARB_PRIORITY_EN
        if (req[0]) begin
            arb_gnt = {{(N_REQ-1){1'b0}}, 1'b1};
        end
`endif
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PtrW'(i);
            end
        end
        rr_next = (gnt_idx == PtrW'(N_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
`ifdef RINGBUF_TX_ARB_PRIORITY_EN
        // A priority grant to requester 0 leaves the rotation where it was.
        if (gnt_q[0]) begin
            rr_next = rr_q;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        bit_ack_d    = '0;
        txda_d       = txda_q;
        frame_done_d = 1'b0;
        rr_d         = rr_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (!(|req)) begin
                    state_d = StIdle;
                end else begin
                    gnt_d     = arb_gnt;
                    bit_cnt_d = '0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (txc_rise) begin
                    if (bit_cnt_q == BitCntW'(FRAME_BITS)) begin
                        txda_d       = IDLE_LEVEL;
                        frame_done_d = 1'b1;
                        gnt_d        = '0;
                        rr_d         = rr_next;
                        gap_cnt_d    = '0;
                        state_d      = (GAP_BITS == 0) ? StIdle : StGap;
                    end else begin
                        txda_d    = txd_in[gnt_idx];
                        bit_ack_d = gnt_q;
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StGap: begin
                if (txc_rise) begin
                    if (gap_cnt_q == GapCntW'(GAP_BITS - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GapCntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            txc_q        <= 1'b0;
            gnt_q        <= '0;
            bit_ack_q    <= '0;
            txda_q       <= IDLE_LEVEL;
            frame_done_q <= 1'b0;
            rr_q         <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            txc_q        <= txc;
            gnt_q        <= gnt_d;
            bit_ack_q    <= bit_ack_d;
            txda_q       <= txda_d;
            frame_done_q <= frame_done_d;
            rr_q         <= rr_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign bit_ack    = bit_ack_q;
    assign txda       = txda_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == StSend) || (state_q == StGap);

endmodule
